// File: rtl/mda_adc_avg.sv
// mda_adc_avg: per-channel block-average filter behind the ADC serial controller.
// Accumulates 2^LOG2_N samples per channel, streams one average per block, and
// keeps the latest average of every channel in a readback bank with a fresh flag.
//
// Ports:
//   slave_clk      - clock for all logic
//   slave_reset_n  - asynchronous active-low reset
//   clear          - synchronous clear of accumulators, counters and fresh flags
//   sample_valid   - strobe qualifying sample_ch / sample_data
//   sample_ch      - channel index of the incoming sample
//   sample_data    - unsigned ADC result
//   avg_valid      - one-cycle strobe qualifying avg_ch / avg_data
//   avg_ch         - channel of the completed average
//   avg_data       - completed block average (truncated)
//   rd_addr        - readback channel select
//   rd_data        - {zero pad, fresh, avg_bank[rd_addr]}, combinational
//   rd_ack         - clears the fresh flag of channel rd_addr
module mda_adc_avg #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned LOG2_N = 4,
  parameter int unsigned DW     = 12
) (
  input  logic          slave_clk,
  input  logic          slave_reset_n,
  input  logic          clear,
  input  logic          sample_valid,
  input  logic [2:0]    sample_ch,
  input  logic [DW-1:0] sample_data,
  output logic          avg_valid,
  output logic [2:0]    avg_ch,
  output logic [DW-1:0] avg_data,
  input  logic [2:0]    rd_addr,
  output logic [31:0]   rd_data,
  input  logic          rd_ack
);

  localparam int unsigned N    = 1 << LOG2_N;
  localparam int unsigned CW   = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int unsigned AW   = DW + LOG2_N;
  localparam int unsigned PADW = 32 - DW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // Per-channel state
  logic [AW-1:0]     r_acc   [NUM_CH];
  logic [CW-1:0]     r_cnt   [NUM_CH];
  logic [DW-1:0]     r_bank  [NUM_CH];
  logic [NUM_CH-1:0] r_fresh;

  // Sample routing and shared datapath
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_ack;
  logic [AW-1:0]     w_sel_acc;
  logic [CW-1:0]     w_sel_cnt;
  logic [AW-1:0]     w_sum;
  logic [DW-1:0]     w_avg;
  logic              w_take;
  logic              w_done;

  // Decode the addressed channel; out-of-range indices match no channel and are dropped.
  always_comb begin
    w_hit     = '0;
    w_ack     = '0;
    w_sel_acc = '0;
    w_sel_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sample_ch == 3'(i)) begin
        w_hit[i]  = sample_valid & ~clear;
        w_sel_acc = r_acc[i];
        w_sel_cnt = r_cnt[i];
      end
      w_ack[i] = rd_ack & (rd_addr == 3'(i));
    end
  end

  // Sum cannot overflow: (2^DW-1)*N fits in DW+LOG2_N bits.
  assign w_take = |w_hit;
  assign w_sum  = w_sel_acc + AW'(sample_data);
  assign w_done = w_take & (w_sel_cnt == CNT_LAST);
  assign w_avg  = DW'(w_sum >> LOG2_N);

  // Streaming output; w_done already excludes clear.
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      avg_valid <= 1'b0;
      avg_ch    <= '0;
      avg_data  <= '0;
    end else begin
      avg_valid <= w_done;
      if (w_done) begin
        avg_ch   <= sample_ch;
        avg_data <= w_avg;
      end
    end
  end

  // Accumulators, counters, readback bank and fresh flags.
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_fresh <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i]  <= '0;
        r_cnt[i]  <= '0;
        r_bank[i] <= '0;
      end
    end else if (clear) begin
      // Bank keeps its last averages across a clear.
      r_fresh <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_hit[i] && (r_cnt[i] == CNT_LAST)) begin
          // Block complete: publish and restart; set beats a same-cycle ack.
          r_acc[i]   <= '0;
          r_cnt[i]   <= '0;
          r_bank[i]  <= w_avg;
          r_fresh[i] <= 1'b1;
        end else begin
          if (w_hit[i]) begin
            r_acc[i] <= w_sum;
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
          if (w_ack[i]) begin
            r_fresh[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Readback mux; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 3'(i)) begin
        rd_data = {{PADW{1'b0}}, r_fresh[i], r_bank[i]};
      end
    end
  end

endmodule

// File: tb/tb_mda_adc_avg.sv
// tb_mda_adc_avg: directed bench for mda_adc_avg. Three instances share the
// stimulus: 8 channels / N=16 (main), 4 channels / N=16, 8 channels / N=1.
module tb_mda_adc_avg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic [2:0]  sample_ch = '0;
  logic [11:0] sample_data = '0;
  logic [2:0]  rd_addr = '0;
  logic        rd_ack = 1'b0;

  logic        avg_valid,  avg_valid4,  avg_valid0;
  logic [2:0]  avg_ch,     avg_ch4,     avg_ch0;
  logic [11:0] avg_data,   avg_data4,   avg_data0;
  logic [31:0] rd_data,    rd_data4,    rd_data0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mda_adc_avg #(.NUM_CH(8), .LOG2_N(4), .DW(12)) dut (
    .slave_clk(clk), .slave_reset_n(rst_n), .clear(clear),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack));

  mda_adc_avg #(.NUM_CH(4), .LOG2_N(4), .DW(12)) dut4 (
    .slave_clk(clk), .slave_reset_n(rst_n), .clear(clear),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .avg_valid(avg_valid4), .avg_ch(avg_ch4), .avg_data(avg_data4),
    .rd_addr(rd_addr), .rd_data(rd_data4), .rd_ack(rd_ack));

  mda_adc_avg #(.NUM_CH(8), .LOG2_N(0), .DW(12)) dut0 (
    .slave_clk(clk), .slave_reset_n(rst_n), .clear(clear),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .avg_valid(avg_valid0), .avg_ch(avg_ch0), .avg_data(avg_data0),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_ack(rd_ack));

  typedef struct {
    logic        v;
    logic [2:0]  ch;
    logic [11:0] d;
    logic        ev;
    logic [2:0]  ech;
    logic [11:0] ed;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [2:0] ch, input logic [11:0] d);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
    tick();
  endtask

  initial begin
    // Passthrough vectors for the N=1 instance
    tbl[0] = '{1'b1, 3'd0, 12'h000, 1'b1, 3'd0, 12'h000};
    tbl[1] = '{1'b1, 3'd7, 12'hFFF, 1'b1, 3'd7, 12'hFFF};
    tbl[2] = '{1'b0, 3'd3, 12'h555, 1'b0, 3'd0, 12'h000};
    tbl[3] = '{1'b1, 3'd3, 12'h555, 1'b1, 3'd3, 12'h555};
    tbl[4] = '{1'b1, 3'd6, 12'hABC, 1'b1, 3'd6, 12'hABC};
    tbl[5] = '{1'b1, 3'd6, 12'h001, 1'b1, 3'd6, 12'h001};
    tbl[6] = '{1'b1, 3'd1, 12'h800, 1'b1, 3'd1, 12'h800};
    tbl[7] = '{1'b1, 3'd5, 12'h7FF, 1'b1, 3'd5, 12'h7FF};

    // Reset state
    repeat (2) tick();
    chk("rst_valid_held", 32'(avg_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 32'(avg_valid), 32'd0);
    chk("rst_data", 32'(avg_data), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      chk($sformatf("rst_rd%0d", a), rd_data, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      put(3'd0, 12'd5);
      chk("partial_no_valid", 32'(avg_valid), 32'd0);
    end
    // Clear with a simultaneous sample: N=1 instance must not pass it through
    clear = 1'b1;
    put(3'd0, 12'd5);
    chk("clr_prio_n1", 32'(avg_valid0), 32'd0);
    chk("clr_prio_main", 32'(avg_valid), 32'd0);
    clear = 1'b0;
    sample_valid = 1'b0;
    rd_addr = 3'd0;
    #1;
    chk("clr_keeps_bank_n1", rd_data0, 32'h0000_0005);

    // Basic average: ch2, 0..15 -> 7
    for (int i = 0; i < 16; i++) begin
      put(3'd2, 12'(i));
      if (i < 15) chk("basic_early", 32'(avg_valid), 32'd0);
    end
    chk("basic_valid", 32'(avg_valid), 32'd1);
    chk("basic_ch", 32'(avg_ch), 32'd2);
    chk("basic_data", 32'(avg_data), 32'd7);
    sample_valid = 1'b0;
    tick();
    chk("basic_pulse_end", 32'(avg_valid), 32'd0);
    rd_addr = 3'd2;
    #1;
    chk("basic_rd_fresh", rd_data, 32'h0000_1007);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    #1;
    chk("basic_rd_acked", rd_data, 32'h0000_0007);

    // Interleave ch0=FFF / ch7=001 every cycle
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) put(3'd0, 12'hFFF);
      else            put(3'd7, 12'h001);
      if (k == 30) begin
        chk("il_v0", 32'(avg_valid), 32'd1);
        chk("il_ch0", 32'(avg_ch), 32'd0);
        chk("il_d0", 32'(avg_data), 32'hFFF);
      end else if (k == 31) begin
        chk("il_v7", 32'(avg_valid), 32'd1);
        chk("il_ch7", 32'(avg_ch), 32'd7);
        chk("il_d7", 32'(avg_data), 32'h001);
      end else begin
        chk("il_idle", 32'(avg_valid), 32'd0);
      end
    end
    sample_valid = 1'b0;
    tick();
    chk("il_end", 32'(avg_valid), 32'd0);

    // Clear priority on ch1, with a prior bank value of 50
    for (int i = 0; i < 16; i++) put(3'd1, 12'd50);
    chk("cp_pre_data", 32'(avg_data), 32'd50);
    for (int i = 0; i < 15; i++) begin
      put(3'd1, 12'd100);
      chk("cp_fill", 32'(avg_valid), 32'd0);
    end
    clear = 1'b1;
    put(3'd1, 12'd100);
    chk("cp_dropped", 32'(avg_valid), 32'd0);
    clear = 1'b0;
    sample_valid = 1'b0;
    rd_addr = 3'd1;
    #1;
    chk("cp_bank_kept", rd_data, 32'h0000_0032);
    for (int i = 0; i < 16; i++) begin
      put(3'd1, 12'd200);
      if (i == 7) chk("cp_bank_mid", rd_data, 32'h0000_0032);
      if (i < 15) chk("cp_refill", 32'(avg_valid), 32'd0);
    end
    chk("cp_valid", 32'(avg_valid), 32'd1);
    chk("cp_data", 32'(avg_data), 32'd200);
    sample_valid = 1'b0;
    #1;
    chk("cp_rd_new", rd_data, 32'h0000_10C8);

    // Out-of-range channel on the 4-channel instance
    for (int i = 0; i < 16; i++) begin
      put(3'd5, 12'd9);
      chk("oor_no_valid4", 32'(avg_valid4), 32'd0);
    end
    chk("oor_main_valid", 32'(avg_valid), 32'd1);
    chk("oor_main_data", 32'(avg_data), 32'd9);
    sample_valid = 1'b0;
    rd_addr = 3'd5;
    #1;
    chk("oor_rd5", rd_data4, 32'd0);
    rd_addr = 3'd1;
    #1;
    chk("oor_ch1_intact", rd_data4, 32'h0000_10C8);

    // Ack / completion collision on ch3
    for (int i = 0; i < 15; i++) put(3'd3, 12'h123);
    rd_addr = 3'd3;
    rd_ack  = 1'b1;
    put(3'd3, 12'h123);
    rd_ack = 1'b0;
    sample_valid = 1'b0;
    chk("col_valid", 32'(avg_valid), 32'd1);
    chk("col_data", 32'(avg_data), 32'h123);
    chk("col_fresh", rd_data, 32'h0000_1123);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    #1;
    chk("col_acked", rd_data, 32'h0000_0123);

    // Table-driven passthrough on the N=1 instance
    for (int t = 0; t < 8; t++) begin
      sample_valid = tbl[t].v;
      sample_ch    = tbl[t].ch;
      sample_data  = tbl[t].d;
      tick();
      chk($sformatf("tbl%0d_valid", t), 32'(avg_valid0), 32'(tbl[t].ev));
      if (tbl[t].ev) begin
        chk($sformatf("tbl%0d_ch", t), 32'(avg_ch0), 32'(tbl[t].ech));
        chk($sformatf("tbl%0d_data", t), 32'(avg_data0), 32'(tbl[t].ed));
      end
    end
    sample_valid = 1'b0;
    rd_addr = 3'd6;
    #1;
    chk("tbl_rd6", rd_data0, 32'h0000_1001);

    // Reset mid-block discards the partial accumulation
    for (int i = 0; i < 8; i++) put(3'd4, 12'd40);
    sample_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_addr = 3'd1;
    #1;
    chk("mid_rst_bank", rd_data, 32'd0);
    chk("mid_rst_valid", 32'(avg_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      put(3'd4, 12'd40);
      if (i < 15) chk("mid_rst_refill", 32'(avg_valid), 32'd0);
    end
    chk("mid_rst_done", 32'(avg_valid), 32'd1);
    chk("mid_rst_data", 32'(avg_data), 32'd40);
    sample_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
